// File: rtl/uart_tx_arbiter_if.sv
// Shared UART write channel bundle: NUM_REQ requester byte streams plus the single uart port.
// The slave modport is the arbiter's view; master is the requester/uart environment view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           uart_wr_data;
    logic                 uart_wr_valid;
    logic                 uart_wr_ready;

    modport slave (
        input  req_data, req_valid, req_last, uart_wr_ready,
        output req_ready, uart_wr_data, uart_wr_valid
    );

    modport master (
        output req_data, req_valid, req_last, uart_wr_ready,
        input  req_ready, uart_wr_data, uart_wr_valid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter for the shared UART write channel.
// Optional stall watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus,
    output logic [ID_W-1:0]     grant_id,
    output logic                busy,
    output logic                arb_timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand;
    logic            any_req;
    logic            xfer;
    logic            pkt_done;
    logic            timeout_hit;

    // Round-robin pick: scanning k downwards lets the nearest valid index after last_grant win.
    always_comb begin
        any_req = |bus.req_valid;
        pick    = last_grant;
        cand    = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (bus.req_valid[cand]) pick = cand;
        end
    end

    assign xfer     = (state == GRANT) && bus.req_valid[grant_id] && bus.uart_wr_ready;
    assign pkt_done = xfer && bus.req_last[grant_id];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (state != GRANT || xfer) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == GRANT) && !xfer && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            grant_id    <= '0;
            busy        <= 1'b0;
            arb_timeout <= 1'b0;
            last_grant  <= ID_W'(NUM_REQ - 1);
        end else begin
            state       <= state_next;
            arb_timeout <= timeout_hit;
            if (state == IDLE && any_req) begin
                grant_id <= pick;
                busy     <= 1'b1;
            end
            if (state == GRANT && (pkt_done || timeout_hit)) begin
                last_grant <= grant_id;
                busy       <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = GRANT;
            GRANT:   if (pkt_done || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        bus.uart_wr_data  = '0;
        bus.uart_wr_valid = 1'b0;
        bus.req_ready     = '0;
        if (state == GRANT) begin
            bus.uart_wr_data        = bus.req_data[{grant_id, 3'b000} +: 8];
            bus.uart_wr_valid       = bus.req_valid[grant_id];
            bus.req_ready[grant_id] = bus.uart_wr_ready;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues feed the DUT, a posedge monitor logs uart bytes.
// Timeout expectations switch on UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 16;

    typedef struct {
        int         cyc;
        logic [1:0] src;
        logic [7:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [ID_W-1:0] grant_id;
    logic busy;
    logic arb_timeout;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [8:0] txq [NUM_REQ][$];
    bit         pause [NUM_REQ];
    bit         uart_ready = 1'b1;
    ent_t       log_q [$];

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .grant_id(grant_id), .busy(busy), .arb_timeout(arb_timeout)
    );

    // Requester and uart-ready drivers, updated on the falling edge
    initial begin
        bus.req_data      = '0;
        bus.req_valid     = '0;
        bus.req_last      = '0;
        bus.uart_wr_ready = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (txq[i].size() != 0 && !pause[i]) begin
                    bus.req_valid[i]        = 1'b1;
                    bus.req_last[i]         = txq[i][0][8];
                    bus.req_data[8*i +: 8]  = txq[i][0][7:0];
                end else begin
                    bus.req_valid[i]        = 1'b0;
                    bus.req_last[i]         = 1'b0;
                    bus.req_data[8*i +: 8]  = 8'h00;
                end
            end
            bus.uart_wr_ready = uart_ready;
        end
    end

    // Handshake monitor: logs uart transfers and retires accepted requester bytes
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst && bus.uart_wr_valid && bus.uart_wr_ready)
                log_q.push_back('{cyc, grant_id, bus.uart_wr_data});
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.req_valid[i] && bus.req_ready[i] && txq[i].size() != 0)
                    void'(txq[i].pop_front());
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            txq[i].delete();
            pause[i] = 1'b0;
        end
        uart_ready = 1'b1;
        repeat (3) @(negedge clk);
        log_q.delete();
        rst = 1'b1;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        tests++;
        if (log_q.size() < n) begin
            fails++;
            $display("FAIL %s: byte wait expired, got %0d bytes, required %0d", name, log_q.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        bit pending;
        k = 0;
        pending = 1'b1;
        while (pending && k < budget) begin
            @(posedge clk); #2;
            k++;
            pending = busy;
            for (int i = 0; i < NUM_REQ; i++) if (txq[i].size() != 0) pending = 1'b1;
        end
        tests++;
        if (pending) begin
            fails++;
            $display("FAIL %s: idle wait expired, busy=%0b, required all queues drained", name, busy);
        end
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            obs = {grant_id, busy, arb_timeout, bus.uart_wr_valid, bus.req_ready, bus.uart_wr_data};
            tests++;
            if (obs !== 20'h0) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got 0x%05h, required 0x00000", c, obs);
            end
        end
    endtask

    task automatic test_hello();
        int c0;
        @(posedge clk); #2;
        c0 = cyc;
        txq[0].push_back({1'b0, 8'h48});
        txq[0].push_back({1'b1, 8'h69});
        wait_idle(50, "hello_idle");
        tests++;
        if (log_q.size() !== 2) begin
            fails++;
            $display("FAIL hello_count: got %0d bytes, required 2", log_q.size());
        end else begin
            tests++;
            if ({log_q[0].data, log_q[1].data} !== 16'h4869) begin
                fails++;
                $display("FAIL hello_data: got 0x%02h 0x%02h, required 0x48 0x69", log_q[0].data, log_q[1].data);
            end
            tests++;
            if (log_q[0].cyc !== c0 + 2 || log_q[1].cyc !== c0 + 3) begin
                fails++;
                $display("FAIL hello_timing: got cycles %0d,%0d, required %0d,%0d",
                         log_q[0].cyc, log_q[1].cyc, c0 + 2, c0 + 3);
            end
        end
        @(negedge clk); #1;
        tests++;
        if ({busy, bus.uart_wr_valid, bus.uart_wr_data} !== 10'h0) begin
            fails++;
            $display("FAIL hello_idle_outputs: busy=%0b valid=%0b data=0x%02h, required all 0",
                     busy, bus.uart_wr_valid, bus.uart_wr_data);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #2;
            for (int i = 0; i < NUM_REQ; i++) txq[i].push_back({1'b1, 8'hA0 + 8'(i)});
            wait_idle(100, "rr_idle");
        end
        tests++;
        if (log_q.size() !== 8) begin
            fails++;
            $display("FAIL rr_count: got %0d bytes, required 8", log_q.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                tests++;
                if (log_q[j].data !== 8'hA0 + 8'(j % 4) || log_q[j].src !== 2'(j % 4)) begin
                    fails++;
                    $display("FAIL rr_order[%0d]: got 0x%02h from %0d, required 0x%02h from %0d",
                             j, log_q[j].data, log_q[j].src, 8'hA0 + 8'(j % 4), j % 4);
                end
            end
            for (int j = 1; j < 4; j++) begin
                tests++;
                if (log_q[j].cyc - log_q[j-1].cyc !== 2) begin
                    fails++;
                    $display("FAIL rr_bubble[%0d]: got spacing %0d, required 2", j, log_q[j].cyc - log_q[j-1].cyc);
                end
            end
        end
    endtask

    task automatic test_no_preempt();
        logic [7:0] exp_b [5];
        int base;
        exp_b = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21};
        base  = log_q.size();
        @(posedge clk); #2;
        txq[1].push_back({1'b0, 8'h10});
        txq[1].push_back({1'b0, 8'h11});
        txq[1].push_back({1'b1, 8'h12});
        wait_bytes(base + 1, 50, "nopre_first");
        txq[2].push_back({1'b0, 8'h20});
        txq[2].push_back({1'b1, 8'h21});
        wait_idle(100, "nopre_idle");
        tests++;
        if (log_q.size() !== base + 5) begin
            fails++;
            $display("FAIL nopre_count: got %0d bytes, required %0d", log_q.size() - base, 5);
        end else begin
            for (int j = 0; j < 5; j++) begin
                tests++;
                if (log_q[base+j].data !== exp_b[j]) begin
                    fails++;
                    $display("FAIL nopre_order[%0d]: got 0x%02h, required 0x%02h", j, log_q[base+j].data, exp_b[j]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int base;
        int stall_len;
        logic [15:0] obs;
`ifdef UART_ARB_TIMEOUT_EN
        stall_len = 10;
`else
        stall_len = 50;
`endif
        base = log_q.size();
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) txq[3].push_back({(i == 3), 8'h30 + 8'(i)});
        wait_bytes(base + 1, 50, "stall_first");
        uart_ready = 1'b0;
        for (int c = 0; c < stall_len; c++) begin
            @(negedge clk); #1;
            obs = {bus.uart_wr_valid, bus.uart_wr_data, grant_id, busy, bus.req_ready};
            tests++;
            if (obs !== {1'b1, 8'h31, 2'd3, 1'b1, 4'b0000}) begin
                fails++;
                $display("FAIL stall_hold cycle %0d: got 0x%04h, required 0x%04h", c, obs,
                         {1'b1, 8'h31, 2'd3, 1'b1, 4'b0000});
            end
        end
        uart_ready = 1'b1;
        wait_idle(100, "stall_idle");
        tests++;
        if (log_q.size() !== base + 4) begin
            fails++;
            $display("FAIL stall_count: got %0d bytes, required 4", log_q.size() - base);
        end else begin
            for (int j = 0; j < 4; j++) begin
                tests++;
                if (log_q[base+j].data !== 8'h30 + 8'(j)) begin
                    fails++;
                    $display("FAIL stall_data[%0d]: got 0x%02h, required 0x%02h", j, log_q[base+j].data, 8'h30 + 8'(j));
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] exp_b [4];
        int base;
        int k;
        base = log_q.size();
        @(posedge clk); #2;
        txq[2].push_back({1'b0, 8'h40});
        txq[2].push_back({1'b0, 8'h41});
        txq[2].push_back({1'b1, 8'h42});
        wait_bytes(base + 1, 50, "tmo_first");
        pause[2] = 1'b1;
        txq[3].push_back({1'b1, 8'h50});
`ifdef UART_ARB_TIMEOUT_EN
        exp_b = '{8'h40, 8'h50, 8'h41, 8'h42};
        k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while (!arb_timeout && k < 100);
        tests++;
        if (k !== TIMEOUT + 1) begin
            fails++;
            $display("FAIL tmo_pulse_time: got pulse at cycle %0d, required %0d", k, TIMEOUT + 1);
        end
        @(negedge clk); #1;
        tests++;
        if (arb_timeout !== 1'b0) begin
            fails++;
            $display("FAIL tmo_pulse_width: got arb_timeout=%0b one cycle later, required 0", arb_timeout);
        end
        wait_bytes(base + 2, 20, "tmo_req3");
        pause[2] = 1'b0;
`else
        exp_b = '{8'h40, 8'h41, 8'h42, 8'h50};
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            tests++;
            if ({busy, grant_id, arb_timeout, bus.uart_wr_valid} !== 5'b1_10_0_0) begin
                fails++;
                $display("FAIL tmo_blocked cycle %0d: busy=%0b grant=%0d timeout=%0b valid=%0b, required 1 2 0 0",
                         c, busy, grant_id, arb_timeout, bus.uart_wr_valid);
            end
        end
        tests++;
        if (log_q.size() !== base + 1) begin
            fails++;
            $display("FAIL tmo_no_leak: got %0d bytes, required 1", log_q.size() - base);
        end
        pause[2] = 1'b0;
`endif
        wait_idle(100, "tmo_idle");
        tests++;
        if (log_q.size() !== base + 4) begin
            fails++;
            $display("FAIL tmo_count: got %0d bytes, required 4", log_q.size() - base);
        end else begin
            for (int j = 0; j < 4; j++) begin
                tests++;
                if (log_q[base+j].data !== exp_b[j]) begin
                    fails++;
                    $display("FAIL tmo_order[%0d]: got 0x%02h, required 0x%02h", j, log_q[base+j].data, exp_b[j]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hello();
        test_round_robin();
        test_no_preempt();
        test_stall();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
